w_sched_ctrl: RTL and testbench
===============================

Name: w_sched_ctrl

Overview:
Sequencer for the SHA-256 message schedule. It accepts one 512-bit padded block and streams W[0]..W[W_LENGTH-1] to the compression-round logic, one word per handshake. It keeps a 16-word sliding window and computes each expanded word on demand. It sits between the block padder and the round engine, and it gates schedule expansion so that no word is produced until the round engine consumes the previous one.

Parameters:
W_LENGTH, 64, number of schedule words streamed per block; must be at least 17 and at most 64.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high; clears all state.
start  input  1  request to begin a block; sampled only in IDLE.
block_in  input  512  padded message block; word i = block_in[511-32*i -: 32], big-endian.
abort  input  1  synchronous cancel of the current block.
w_ready  input  1  round engine accepts w_out this cycle.
busy  output  1  high while a block is in progress (STREAM).
w_valid  output  1  w_out and w_index are valid.
w_out  output  32  schedule word W[w_index].
w_index  output  6  index t of the word on w_out.
block_done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (priority over every other input): state=IDLE; busy=0, w_valid=0, w_out=0, w_index=0, block_done=0; window cleared.
- States: IDLE, STREAM.
- IDLE with start=1:
  - Load window win[i] = M[i] for i = 0..15 (win[0] oldest).
  - Set t=0 and move to STREAM.
  - On the next cycle busy=1, w_valid=1, w_index=0. Latency from start to the first valid word is 1 cycle.
- start in STREAM is ignored; block_in is not re-sampled.
- STREAM: w_valid=1 continuously. w_out is combinational from the window and t, and must be stable while w_ready=0:
  - t<16: w_out = win[0].
  - t>=16: w_out = sig1(win[14]) + win[9] + sig0(win[1]) + win[0], all mod 2^32.
  - sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Handshake (w_valid && w_ready):
  - Window shifts: win[i] <= win[i+1] for i = 0..14, and win[15] <= w_out. For t<16 this rotates the message back into place, so after 16 accepts the window holds W[0..15].
  - t <= t+1.
- Final accept (t = W_LENGTH-1):
  - State goes to IDLE; busy=0 and w_valid=0 next cycle.
  - block_done=1 for exactly that next cycle.
  - w_index holds W_LENGTH-1.
- A start during the block_done cycle is accepted, giving back-to-back blocks with a 1-cycle valid gap.
- w_ready while w_valid=0 has no effect.
- abort=1 in STREAM (priority over handshake): go to IDLE; busy=0, w_valid=0 next cycle; no block_done; t=0; window contents don't-care.
- abort in IDLE: no effect. If abort and start are both high in IDLE, start wins.
- Stalls of any length are allowed; outputs are held unchanged.
- No combinational path from w_ready to w_valid.
- At most one word per cycle; sustained throughput is 1 word/cycle when w_ready=1.

Test Plan:
1. Block "abc" (W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018), w_ready=1 always -> exactly 64 words in 64 consecutive cycles; W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[63]=0x12B1EDEB; block_done pulses once, on the cycle after the t=63 accept.
2. Same block, w_ready toggling 1,0,0,1,... -> identical W sequence; w_out and w_index are held during every stall; total words = 64.
3. Reset asserted while in STREAM at t=30 -> next cycle all outputs are 0 and state is IDLE; a new start with the "abc" block then yields W[0]=0x61626380 at w_index 0.
4. abort at t=20 -> next cycle w_valid=0 and busy=0, no block_done; a following start replays the full 64-word sequence correctly.
5. start held high through a block, with a second block (all-zero block_in) asserted in the block_done cycle -> second block starts with a 1-cycle gap; all W[t] for the second block are 0; start pulses during STREAM are ignored.
6. W_LENGTH=17 build -> 17 words stream, last word W[16]=0x61626380 for "abc", then block_done.

Source files
------------

// File: rtl/w_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | w_sched_ctrl: SHA-256 message-schedule sequencer, one W[t] per handshake.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module w_sched_ctrl #(
  parameter int W_LENGTH = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         abort,
  input  logic         w_ready,
  output logic         busy,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         block_done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [5:0] LAST_T = 6'(W_LENGTH - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic [31:0] expanded;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign w_index = t;

  // Words below 16 are the message itself, rotated through the window.
  always_comb begin
    expanded = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    w_out    = '0;
    if (busy) begin
      w_out = (t < 6'd16) ? win[0] : expanded;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      w_valid    <= 1'b0;
      block_done <= 1'b0;
      t          <= '0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              win[i] <= block_in[511-32*i -: 32];
            end
            t       <= '0;
            state   <= STREAM;
            busy    <= 1'b1;
            w_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            w_valid <= 1'b0;
            t       <= '0;
          end else if (w_ready) begin
            for (int i = 0; i < 15; i++) begin
              win[i] <= win[i+1];
            end
            win[15] <= w_out;
            // t is left at the last index so w_index holds it after the block.
            if (t == LAST_T) begin
              state      <= IDLE;
              busy       <= 1'b0;
              w_valid    <= 1'b0;
              block_done <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_w_sched_ctrl.sv
`default_nettype none
// Scoreboard bench for w_sched_ctrl: reference schedule expansion, stalls,
// reset/abort mid-block, back-to-back blocks and a W_LENGTH=17 instance.
module tb_w_sched_ctrl;

  logic         clock = 1'b0;
  logic         reset, start, abort, w_ready;
  logic [511:0] block_in;
  logic         busy, w_valid, block_done;
  logic [31:0]  w_out;
  logic [5:0]   w_index;

  logic         start17, ready17;
  logic         busy17, valid17, done17;
  logic [31:0]  out17;
  logic [5:0]   idx17;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] val;
  } item_t;

  item_t       sbq[$];
  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  always #5 clock = ~clock;

  w_sched_ctrl #(.W_LENGTH(64)) dut (
    .clock(clock), .reset(reset), .start(start), .block_in(block_in),
    .abort(abort), .w_ready(w_ready), .busy(busy), .w_valid(w_valid),
    .w_out(w_out), .w_index(w_index), .block_done(block_done)
  );

  w_sched_ctrl #(.W_LENGTH(17)) dut17 (
    .clock(clock), .reset(reset), .start(start17), .block_in(block_in),
    .abort(1'b0), .w_ready(ready17), .busy(busy17), .w_valid(valid17),
    .w_out(out17), .w_index(idx17), .block_done(done17)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full-array expansion of the SHA-256 schedule.
  task automatic build_exp(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
  endtask

  task automatic push_block(input logic [511:0] b, input int len);
    item_t it;
    build_exp(b);
    for (int i = 0; i < len; i++) begin
      it.idx = 6'(i);
      it.val = exp_w[i];
      sbq.push_back(it);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the load.
  task automatic start_block(input logic [511:0] b);
    block_in = b;
    start    = 1'b1;
    push_block(b, 64);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Streams words against the scoreboard until block_done, a kill, or the cycle budget.
  task automatic drain(input int mode, input int kill_at, input bit kill_reset,
                       input bit hold_start, output int words, output int dones);
    int          k;
    bit          stalled;
    logic [31:0] pv;
    logic [5:0]  pi;
    item_t       it;
    k = 0; stalled = 1'b0; pv = '0; pi = '0;
    words = 0; dones = 0;
    start = hold_start;
    if (hold_start) block_in = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (block_done === 1'b1) begin
        dones++;
        if (start) push_block(block_in, 64);
        return;
      end
      if (w_valid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL valid_gap: w_valid=%b required 1 (cycle %0d)", w_valid, cyc);
        return;
      end
      if (stalled) begin
        checks++;
        if (w_out !== pv || w_index !== pi) begin
          errors++;
          $display("FAIL stall_hold: w_out=%h idx=%0d required w_out=%h idx=%0d",
                   w_out, w_index, pv, pi);
        end
      end
      if (kill_at >= 0 && int'(w_index) == kill_at) begin
        if (kill_reset) reset = 1'b1; else abort = 1'b1;
        w_ready = 1'b1;
        sbq.delete();
        @(negedge clock);
        reset = 1'b0; abort = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || block_done !== 1'b0 || w_index !== 6'd0) begin
          errors++;
          $display("FAIL kill_outputs: valid=%b busy=%b done=%b idx=%0d required 0 0 0 0",
                   w_valid, busy, block_done, w_index);
        end
        if (kill_reset) begin
          checks++;
          if (w_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_wout: w_out=%h required 00000000", w_out);
          end
        end
        return;
      end
      w_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      k++;
      stalled = !w_ready;
      pv = w_out; pi = w_index;
      if (w_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL extra_word: idx=%0d w_out=%h required no word", w_index, w_out);
        end else begin
          it = sbq.pop_front();
          if (w_index !== it.idx || w_out !== it.val) begin
            errors++;
            $display("FAIL word: idx=%0d w_out=%h required idx=%0d w_out=%h",
                     w_index, w_out, it.idx, it.val);
          end
          obs_w[it.idx] = w_out;
          words++;
        end
      end
      @(negedge clock);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: no block_done within 400 cycles, required completion");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || w_valid !== 1'b0 || w_out !== 32'h0 || w_index !== 6'd0 || block_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b w_out=%h idx=%0d done=%b required all 0",
               busy, w_valid, w_out, w_index, block_done);
    end
    w_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (w_valid !== 1'b0 || w_index !== 6'd0 || valid17 !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: valid=%b idx=%0d valid17=%b required 0 0 0", w_valid, w_index, valid17);
    end
  endtask

  task automatic test_abc_stream();
    int words, dones;
    start_block(ABC);
    drain(0, -1, 1'b0, 1'b0, words, dones);
    checks++;
    if (words !== 64 || dones !== 1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL abc_count: words=%0d dones=%0d left=%0d required 64 1 0", words, dones, sbq.size());
    end
    checks++;
    if (obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000F0000 ||
        obs_w[18] !== 32'h7DA86405 || obs_w[63] !== 32'h12B1EDEB) begin
      errors++;
      $display("FAIL abc_known: W16=%h W17=%h W18=%h W63=%h required 61626380 000f0000 7da86405 12b1edeb",
               obs_w[16], obs_w[17], obs_w[18], obs_w[63]);
    end
    checks++;
    if (w_index !== 6'd63 || busy !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: idx=%0d busy=%b valid=%b required 63 0 0", w_index, busy, w_valid);
    end
    @(negedge clock);
    checks++;
    if (block_done !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b required 0 0", block_done, w_valid);
    end
  endtask

  task automatic test_stall();
    int words, dones;
    start_block(ABC);
    drain(1, -1, 1'b0, 1'b0, words, dones);
    checks++;
    if (words !== 64 || dones !== 1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL stall_count: words=%0d dones=%0d left=%0d required 64 1 0", words, dones, sbq.size());
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int words, dones;
    start_block(ABC);
    drain(0, 30, 1'b1, 1'b0, words, dones);
    start_block(ABC);
    checks++;
    if (w_valid !== 1'b1 || w_index !== 6'd0 || w_out !== 32'h61626380) begin
      errors++;
      $display("FAIL restart_first: valid=%b idx=%0d w_out=%h required 1 0 61626380", w_valid, w_index, w_out);
    end
    drain(0, -1, 1'b0, 1'b0, words, dones);
    checks++;
    if (words !== 64 || dones !== 1) begin
      errors++;
      $display("FAIL restart_count: words=%0d dones=%0d required 64 1", words, dones);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    int words, dones;
    start_block(ABC);
    drain(0, 20, 1'b0, 1'b0, words, dones);
    checks++;
    if (dones !== 0 || words !== 20) begin
      errors++;
      $display("FAIL abort_count: words=%0d dones=%0d required 20 0", words, dones);
    end
    @(negedge clock);
    checks++;
    if (block_done !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b required 0 0", block_done, w_valid);
    end
    abort = 1'b1;
    start_block(ABC);
    abort = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || busy !== 1'b1 || w_index !== 6'd0) begin
      errors++;
      $display("FAIL start_beats_abort: valid=%b busy=%b idx=%0d required 1 1 0", w_valid, busy, w_index);
    end
    drain(0, -1, 1'b0, 1'b0, words, dones);
    checks++;
    if (words !== 64 || dones !== 1) begin
      errors++;
      $display("FAIL abort_replay: words=%0d dones=%0d required 64 1", words, dones);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int words, dones;
    start_block(ABC);
    drain(0, -1, 1'b0, 1'b1, words, dones);
    checks++;
    if (words !== 64 || dones !== 1 || sbq.size() != 64) begin
      errors++;
      $display("FAIL b2b_first: words=%0d dones=%0d queued=%0d required 64 1 64", words, dones, sbq.size());
    end
    checks++;
    if (w_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b required 0", w_valid);
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_index !== 6'd0 || w_out !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second_start: valid=%b idx=%0d w_out=%h required 1 0 00000000", w_valid, w_index, w_out);
    end
    drain(0, -1, 1'b0, 1'b0, words, dones);
    checks++;
    if (words !== 64 || dones !== 1 || obs_w[63] !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second: words=%0d dones=%0d W63=%h required 64 1 00000000", words, dones, obs_w[63]);
    end
    @(negedge clock);
  endtask

  task automatic test_len17();
    logic [31:0] last;
    last = '0;
    build_exp(ABC);
    block_in = ABC;
    start17  = 1'b1;
    ready17  = 1'b1;
    @(negedge clock);
    start17 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (valid17 !== 1'b1 || idx17 !== 6'(i) || out17 !== exp_w[i]) begin
        errors++;
        $display("FAIL len17_word: valid=%b idx=%0d w_out=%h required 1 %0d %h",
                 valid17, idx17, out17, i, exp_w[i]);
      end
      last = out17;
      @(negedge clock);
    end
    checks++;
    if (done17 !== 1'b1 || valid17 !== 1'b0 || idx17 !== 6'd16 || last !== 32'h61626380) begin
      errors++;
      $display("FAIL len17_end: done=%b valid=%b idx=%0d last=%h required 1 0 16 61626380",
               done17, valid17, idx17, last);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
    block_in = '0; start17 = 1'b0; ready17 = 1'b0;
    for (int i = 0; i < 64; i++) obs_w[i] = 'x;
    @(negedge clock);
    test_reset();
    test_abc_stream();
    test_stall();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    test_len17();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
